// File: rtl/rstgen_pkg.sv
// Shared types and constants for the reset sequencer.
package rstgen_pkg;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    HOLD   = 2'd1,
    PERIPH = 2'd2,
    RUN    = 2'd3
  } state_e;

  localparam logic [1:0] RST_CAUSE_EXT = 2'b00;
  localparam logic [1:0] RST_CAUSE_SW  = 2'b01;

  // Larger of two unsigned values, used to size the shared delay counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rstgen_sync.sv
// Reset synchroniser: asserts asynchronously, releases after SyncStages edges.
module rstgen_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_sync_no
);

  (* ASYNC_REG = "TRUE" *) logic [SyncStages-1:0] sync_q;

  // Shift a constant one through the chain once rst_ni is released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], 1'b1};
    end
  end

  assign rst_sync_no = sync_q[SyncStages-1];

endmodule

// File: rtl/rstgen_seq.sv
// Reset sequencer: releases peripheral reset, then core reset, and handles
// software reset requests while running.
module rstgen_seq #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned HoldCycles = 16,
  parameter int unsigned CoreDelay  = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sw_rst_req_i,
  output logic       rst_periph_no,
  output logic       rst_core_no,
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] sw_rst_cnt_o
);

  import rstgen_pkg::*;

  localparam int unsigned CntMax   = max_u(HoldCycles, CoreDelay);
  localparam int unsigned CntW     = $clog2(CntMax + 1);
  localparam int unsigned HoldLast = HoldCycles - 1;
  localparam int unsigned CoreLast = (CoreDelay == 0) ? 0 : CoreDelay - 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rst_sync_n;
  logic            periph_d, core_d, done_d;
  logic [1:0]      cause_d;
  logic [7:0]      sw_cnt_d;

  rstgen_sync #(
    .SyncStages (SyncStages)
  ) u_sync (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rst_sync_no (rst_sync_n)
  );

  // State and delay counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and registered-output next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = rst_cause_o;
    sw_cnt_d = sw_rst_cnt_o;

    unique case (state_q)
      RESET: begin
        if (rst_sync_n) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == CntW'(HoldLast)) begin
          cnt_d   = '0;
          state_d = (CoreDelay == 0) ? RUN : PERIPH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PERIPH: begin
        if (cnt_q == CntW'(CoreLast)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (sw_rst_req_i) begin
          state_d = HOLD;
          cnt_d   = '0;
          cause_d = RST_CAUSE_SW;
          if (sw_rst_cnt_o != 8'hFF) begin
            sw_cnt_d = sw_rst_cnt_o + 8'd1;
          end
        end
      end
    endcase

    // Core release only ever coincides with or follows peripheral release.
    periph_d = (state_d == PERIPH) || (state_d == RUN);
    core_d   = (state_d == RUN);
    done_d   = (state_d == RUN);
  end

  // Glitch-free output flops, cleared directly by the raw reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_periph_no <= 1'b0;
      rst_core_no   <= 1'b0;
      rst_done_o    <= 1'b0;
      rst_cause_o   <= RST_CAUSE_EXT;
      sw_rst_cnt_o  <= 8'd0;
    end else begin
      rst_periph_no <= periph_d;
      rst_core_no   <= core_d;
      rst_done_o    <= done_d;
      rst_cause_o   <= cause_d;
      sw_rst_cnt_o  <= sw_cnt_d;
    end
  end

endmodule

// File: tb/tb_rstgen_seq.sv
// Scoreboard bench for rstgen_seq: default instance plus a HoldCycles=1,
// CoreDelay=0 instance. Every output change is matched against a queued event.
module tb_rstgen_seq;

  logic       clk = 1'b0;
  logic       rst0_n = 1'b1, rst1_n = 1'b1;
  logic       sw0 = 1'b0, sw1 = 1'b0;
  logic       p0, c0, d0, p1, c1, d1;
  logic [1:0] cause0, cause1;
  logic [7:0] cnt0, cnt1;

  always #5 clk = ~clk;

  rstgen_seq dut0 (
    .clk_i         (clk),
    .rst_ni        (rst0_n),
    .sw_rst_req_i  (sw0),
    .rst_periph_no (p0),
    .rst_core_no   (c0),
    .rst_done_o    (d0),
    .rst_cause_o   (cause0),
    .sw_rst_cnt_o  (cnt0)
  );

  rstgen_seq #(
    .HoldCycles (1),
    .CoreDelay  (0)
  ) dut1 (
    .clk_i         (clk),
    .rst_ni        (rst1_n),
    .sw_rst_req_i  (sw1),
    .rst_periph_no (p1),
    .rst_core_no   (c1),
    .rst_done_o    (d1),
    .rst_cause_o   (cause1),
    .sw_rst_cnt_o  (cnt1)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [12:0] obs;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          probe0 = 0, probe1 = 0;
  int          seen0 = 0, seen1 = 0;
  logic        finishing = 1'b0;
  logic [12:0] prev0 = '0, prev1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [12:0] pk(input logic p, input logic c, input logic d,
                                     input logic [1:0] ca, input logic [7:0] n);
    return {p, c, d, ca, n};
  endfunction

  // Pop the next expected event for instance id and compare it.
  task automatic compare(input int id, input logic [12:0] obs);
    exp_t e;
    checks++;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL dut%0d unexpected_event: cycle %0d got obs=%b, none expected", id, cyc, obs);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else         e = q1.pop_front();
    if (e.cyc != cyc || e.obs !== obs) begin
      errors++;
      $display("FAIL dut%0d event: got cycle %0d obs=%b (p,c,d,cause,cnt), expected cycle %0d obs=%b",
               id, cyc, obs, e.cyc, e.obs);
    end
  endtask

  // Monitor: compare on every output change or explicit probe; final drain check.
  always @(negedge clk) begin
    logic [12:0] obs0, obs1;
    if (finishing) begin
      checks++;
      if (q0.size() != 0) begin
        errors++;
        $display("FAIL dut0 leftover: got %0d unseen events, expected 0", q0.size());
      end
      checks++;
      if (q1.size() != 0) begin
        errors++;
        $display("FAIL dut1 leftover: got %0d unseen events, expected 0", q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else begin
      obs0 = pk(p0, c0, d0, cause0, cnt0);
      obs1 = pk(p1, c1, d1, cause1, cnt1);
      if (obs0 !== prev0 || probe0 != seen0) begin
        seen0 = probe0;
        compare(0, obs0);
      end
      if (obs1 !== prev1 || probe1 != seen1) begin
        seen1 = probe1;
        compare(1, obs1);
      end
      prev0 = obs0;
      prev1 = obs1;
      checks++;
      if ((c0 && !p0) || (c1 && !p1)) begin
        errors++;
        $display("FAIL core_before_periph: cycle %0d got core0=%b periph0=%b core1=%b periph1=%b, expected core<=periph",
                 cyc, c0, p0, c1, p1);
      end
    end
  end

  task automatic push0(input int unsigned at, input logic [12:0] o);
    q0.push_back({at, o});
  endtask

  task automatic push1(input int unsigned at, input logic [12:0] o);
    q1.push_back({at, o});
  endtask

  initial begin
    int unsigned c, n;
    logic [7:0]  ce;

    // Asynchronous reset of both instances, then probe the reset state.
    #1;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    @(posedge clk); #1;
    push0(cyc, pk(0, 0, 0, 2'b00, 8'd0)); probe0++;
    push1(cyc, pk(0, 0, 0, 2'b00, 8'd0)); probe1++;
    repeat (3) @(posedge clk);
    #1;

    // Power-on release: periph at edge 19, core/done at edge 27.
    rst0_n = 1'b1;
    c = cyc;
    push0(c + 19, pk(1, 0, 0, 2'b00, 8'd0));
    push0(c + 27, pk(1, 1, 1, 2'b00, 8'd0));
    repeat (35) @(posedge clk);
    #1;

    // Single-cycle software reset pulse.
    sw0 = 1'b1;
    n = cyc + 1;
    push0(n,      pk(0, 0, 0, 2'b01, 8'd1));
    push0(n + 16, pk(1, 0, 0, 2'b01, 8'd1));
    push0(n + 24, pk(1, 1, 1, 2'b01, 8'd1));
    @(posedge clk); #1;
    sw0 = 1'b0;
    repeat (35) @(posedge clk);
    #1;

    // Second software reset, then a 3 ns rst_ni glitch while in PERIPH.
    sw0 = 1'b1;
    n = cyc + 1;
    push0(n,      pk(0, 0, 0, 2'b01, 8'd2));
    push0(n + 16, pk(1, 0, 0, 2'b01, 8'd2));
    @(posedge clk); #1;
    sw0 = 1'b0;
    repeat (18) @(posedge clk);
    #3;
    push0(cyc, pk(0, 0, 0, 2'b00, 8'd0));
    rst0_n = 1'b0;
    #3;
    rst0_n = 1'b1;
    c = cyc;
    push0(c + 19, pk(1, 0, 0, 2'b00, 8'd0));
    push0(c + 27, pk(1, 1, 1, 2'b00, 8'd0));
    repeat (35) @(posedge clk);
    #1;

    // Software request held for 100 sampled edges: four sequences.
    sw0 = 1'b1;
    n = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      push0(n + 25 * k,      pk(0, 0, 0, 2'b01, 8'(k + 1)));
      push0(n + 25 * k + 16, pk(1, 0, 0, 2'b01, 8'(k + 1)));
      push0(n + 25 * k + 24, pk(1, 1, 1, 2'b01, 8'(k + 1)));
    end
    repeat (100) @(posedge clk);
    #1;
    sw0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Short instance: both resets release on edge 4.
    rst1_n = 1'b1;
    c = cyc;
    push1(c + 4, pk(1, 1, 1, 2'b00, 8'd0));
    repeat (8) @(posedge clk);

    // 260 software resets; the count saturates at 255.
    for (int k = 1; k <= 260; k++) begin
      @(posedge clk); #1;
      sw1 = 1'b1;
      n = cyc + 1;
      ce = (k > 255) ? 8'd255 : 8'(k);
      push1(n,     pk(0, 0, 0, 2'b01, ce));
      push1(n + 1, pk(1, 1, 1, 2'b01, ce));
      @(posedge clk); #1;
      sw1 = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1;
    finishing = 1'b1;
  end

endmodule
